// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the Wishbone slave mux
package wb_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  localparam int NUM_SLAVES          = 4;
  localparam int IDX_W               = 2;
  localparam int DEFAULT_SLAVE_SHIFT = 12;
  localparam int CNT_W               = 8;

endpackage

// File: rtl/wb_slave_mux_if.sv
// rtl/wb_slave_mux_if.sv - master-side and peripheral-side bus signals of the slave mux
interface wb_slave_mux_if;
  import wb_pkg::*;

  logic                     m_cyc;
  logic                     m_stb;
  logic                     m_we;
  logic [31:0]              m_addr;
  logic [31:0]              m_data_i;
  logic [31:0]              m_data_o;
  logic                     m_ack;
  logic                     m_err;
  logic [NUM_SLAVES-1:0]    s_cyc;
  logic [NUM_SLAVES-1:0]    s_stb;
  logic                     s_we;
  logic [31:0]              s_addr;
  logic [31:0]              s_data_o;
  logic [NUM_SLAVES*32-1:0] s_data_i;
  logic [NUM_SLAVES-1:0]    s_ack;

  // The CPU driving requests into the mux.
  modport master (
    output m_cyc, m_stb, m_we, m_addr, m_data_i,
    input  m_data_o, m_ack, m_err
  );

  // The mux itself: slave to the CPU, master to the peripherals.
  modport slave (
    input  m_cyc, m_stb, m_we, m_addr, m_data_i, s_data_i, s_ack,
    output m_data_o, m_ack, m_err, s_cyc, s_stb, s_we, s_addr, s_data_o
  );

  // The peripherals answering the mux.
  modport periph (
    input  s_cyc, s_stb, s_we, s_addr, s_data_o,
    output s_data_i, s_ack
  );

endinterface

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - maps a byte address to a slave index and a mapped flag
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int SLAVE_SHIFT = DEFAULT_SLAVE_SHIFT
) (
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             mapped
);

  logic [31:0] field;
  logic [31:0] upper;

  // Shifts rather than slices keep the decode legal for any SLAVE_SHIFT up to 28.
  assign field  = (addr >> SLAVE_SHIFT) & 32'hF;
  assign upper  = addr >> (SLAVE_SHIFT + 4);
  assign idx    = field[IDX_W-1:0];
  assign mapped = (field < NUM_SLAVES) && (upper == 32'd0);

endmodule

// File: rtl/wb_slave_mux.sv
// rtl/wb_slave_mux.sv - single-master to four-slave Wishbone classic mux with bus error on
// unmapped addresses and slave timeout
module wb_slave_mux
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SLAVE_SHIFT    = DEFAULT_SLAVE_SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  wb_slave_mux_if.slave  bus
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_mapped;
  logic [NUM_SLAVES-1:0] cyc_n, stb_n;
  logic                  we_n, ack_n, err_n;
  logic [31:0]           addr_n, wdat_n, rdat_n, sel_data;

  wb_addr_decode #(.SLAVE_SHIFT(SLAVE_SHIFT)) u_dec (
    .addr   (bus.m_addr),
    .idx    (dec_idx),
    .mapped (dec_mapped)
  );

  assign sel_data = bus.s_data_i[{idx, 5'd0} +: 32];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    cyc_n   = bus.s_cyc;
    stb_n   = bus.s_stb;
    we_n    = bus.s_we;
    addr_n  = bus.s_addr;
    wdat_n  = bus.s_data_o;
    rdat_n  = bus.m_data_o;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        // The master still holds stb during the response cycle; don't re-issue it.
        if (bus.m_cyc && bus.m_stb && !bus.m_ack && !bus.m_err) begin
          if (dec_mapped) begin
            idx_n   = dec_idx;
            we_n    = bus.m_we;
            addr_n  = bus.m_addr;
            wdat_n  = bus.m_data_i;
            cyc_n   = NUM_SLAVES'(1) << dec_idx;
            stb_n   = NUM_SLAVES'(1) << dec_idx;
            cnt_n   = '0;
            state_n = ACTIVE;
          end else begin
            err_n   = 1'b1;
            state_n = ERR;
          end
        end
      end
      ACTIVE: begin
        if (bus.s_ack[idx]) begin
          cyc_n   = '0;
          stb_n   = '0;
          ack_n   = 1'b1;
          state_n = IDLE;
          if (!bus.s_we) rdat_n = sel_data;
        end else if (!bus.m_cyc) begin
          cyc_n   = '0;
          stb_n   = '0;
          state_n = IDLE;
        end else if (cnt == TO_LAST) begin
          cyc_n   = '0;
          stb_n   = '0;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      bus.s_cyc    <= '0;
      bus.s_stb    <= '0;
      bus.s_we     <= 1'b0;
      bus.s_addr   <= '0;
      bus.s_data_o <= '0;
      bus.m_data_o <= '0;
      bus.m_ack    <= 1'b0;
      bus.m_err    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      bus.s_cyc    <= cyc_n;
      bus.s_stb    <= stb_n;
      bus.s_we     <= we_n;
      bus.s_addr   <= addr_n;
      bus.s_data_o <= wdat_n;
      bus.m_data_o <= rdat_n;
      bus.m_ack    <= ack_n;
      bus.m_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb/tb_wb_slave_mux.sv - directed vector bench for wb_slave_mux
module tb_wb_slave_mux;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  wb_slave_mux_if bus();

  wb_slave_mux #(.TIMEOUT_CYCLES(16), .SLAVE_SHIFT(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_stb;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_master;
    bus.m_cyc = 1'b0;
    bus.m_stb = 1'b0;
    bus.m_we  = 1'b0;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m_cyc    = 1'b1;
    bus.m_stb    = 1'b1;
    bus.m_we     = we;
    bus.m_addr   = addr;
    bus.m_data_i = wdata;
  endtask

  // One transaction against a slave that acks the cycle after it sees stb.
  task automatic run_vec(input vec_t v);
    request(v.we, v.addr, v.wdata);
    tick;
    chk("c1_stb", {28'd0, bus.s_stb}, {28'd0, v.exp_stb});
    chk("c1_cyc", {28'd0, bus.s_cyc}, {28'd0, v.exp_stb});
    chk("c1_err", {31'd0, bus.m_err}, {31'd0, v.exp_err});
    chk("c1_ack", {31'd0, bus.m_ack}, 32'd0);
    if (v.exp_err) begin
      idle_master();
      tick;
      chk("c2_err_pulse", {31'd0, bus.m_err}, 32'd0);
      chk("c2_err_stb", {28'd0, bus.s_stb}, 32'd0);
      chk("c2_err_ack", {31'd0, bus.m_ack}, 32'd0);
    end else begin
      chk("c1_addr", bus.s_addr, v.addr);
      chk("c1_we", {31'd0, bus.s_we}, {31'd0, v.we});
      if (v.we) chk("c1_wdata", bus.s_data_o, v.wdata);
      tick;
      bus.s_ack = v.exp_stb;
      chk("c2_ack", {31'd0, bus.m_ack}, 32'd0);
      chk("c2_stb", {28'd0, bus.s_stb}, {28'd0, v.exp_stb});
      tick;
      bus.s_ack = 4'b0000;
      chk("c3_ack", {31'd0, bus.m_ack}, 32'd1);
      chk("c3_err", {31'd0, bus.m_err}, 32'd0);
      chk("c3_stb", {28'd0, bus.s_stb}, 32'd0);
      chk("c3_data", bus.m_data_o, v.exp_data);
      tick;
      chk("c4_no_reissue", {28'd0, bus.s_stb}, 32'd0);
      chk("c4_ack_pulse", {31'd0, bus.m_ack}, 32'd0);
      idle_master();
      tick;
    end
  endtask

  int   n;
  logic seen;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0,         4'b0010, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h0000_0001, 4'b0001, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0001_0000, 32'h0,         4'b0000, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_5000, 32'h0,         4'b0000, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_3ABC, 32'h0,         4'b1000, 1'b0, 32'h3333_3333};
    vecs[5] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0001, 1'b0, 32'hA0A0_0000};
    vecs[6] = '{1'b1, 32'h0000_2010, 32'h1234_5678, 4'b0100, 1'b0, 32'hA0A0_0000};
    vecs[7] = '{1'b0, 32'h8000_1000, 32'h0,         4'b0000, 1'b1, 32'h0};

    idle_master();
    bus.m_addr   = '0;
    bus.m_data_i = '0;
    bus.s_ack    = 4'b0000;
    bus.s_data_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA0A0_0000};

    repeat (3) tick;
    chk("rst_ack", {31'd0, bus.m_ack}, 32'd0);
    chk("rst_err", {31'd0, bus.m_err}, 32'd0);
    chk("rst_stb", {28'd0, bus.s_stb}, 32'd0);
    chk("rst_cyc", {28'd0, bus.s_cyc}, 32'd0);
    chk("rst_data", bus.m_data_o, 32'd0);
    chk("rst_addr", bus.s_addr, 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Slave 2 never answers: 16 strobe cycles, then an error pulse.
    request(1'b0, 32'h0000_2000, 32'h0);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.m_ack) seen = 1'b1;
      if (bus.s_stb[2]) n++;
      else break;
    end
    chk("to_stb_cycles", n, 32'd16);
    chk("to_err", {31'd0, bus.m_err}, 32'd1);
    chk("to_stb_low", {28'd0, bus.s_stb}, 32'd0);
    idle_master();
    tick;
    chk("to_err_pulse", {31'd0, bus.m_err}, 32'd0);
    repeat (4) tick;
    bus.s_ack = 4'b0100;
    tick;
    bus.s_ack = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      if (bus.m_ack || bus.m_err) seen = 1'b1;
      tick;
    end
    chk("to_late_ack", {31'd0, seen}, 32'd0);

    // Ack on the last allowed strobe cycle beats the timeout.
    request(1'b0, 32'h0000_2000, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.s_stb[2]) begin
        n++;
        if (n == 16) begin
          bus.s_ack = 4'b0100;
          break;
        end
      end else break;
    end
    chk("edge_stb_cycles", n, 32'd16);
    tick;
    bus.s_ack = 4'b0000;
    chk("edge_ack", {31'd0, bus.m_ack}, 32'd1);
    chk("edge_err", {31'd0, bus.m_err}, 32'd0);
    chk("edge_data", bus.m_data_o, 32'h2222_2222);
    idle_master();
    tick;

    // Master abort in the third active cycle.
    request(1'b0, 32'h0000_1000, 32'h0);
    repeat (3) tick;
    chk("ab_stb_c3", {28'd0, bus.s_stb}, 32'h2);
    idle_master();
    tick;
    chk("ab_stb", {28'd0, bus.s_stb}, 32'd0);
    chk("ab_cyc", {28'd0, bus.s_cyc}, 32'd0);
    chk("ab_ack", {31'd0, bus.m_ack}, 32'd0);
    chk("ab_err", {31'd0, bus.m_err}, 32'd0);
    tick;
    chk("ab_ack2", {31'd0, bus.m_ack}, 32'd0);
    chk("ab_err2", {31'd0, bus.m_err}, 32'd0);

    run_vec('{1'b0, 32'h0000_0000, 32'h0, 4'b0001, 1'b0, 32'hA0A0_0000});
    run_vec('{1'b0, 32'h0000_3000, 32'h0, 4'b1000, 1'b0, 32'h3333_3333});

    // Asynchronous reset in the middle of an active transaction.
    request(1'b0, 32'h0000_1000, 32'h0);
    tick;
    chk("rs_stb_before", {28'd0, bus.s_stb}, 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("rs_stb", {28'd0, bus.s_stb}, 32'd0);
    chk("rs_cyc", {28'd0, bus.s_cyc}, 32'd0);
    chk("rs_ack", {31'd0, bus.m_ack}, 32'd0);
    chk("rs_err", {31'd0, bus.m_err}, 32'd0);
    chk("rs_data", bus.m_data_o, 32'd0);
    idle_master();
    tick;
    rst = 1'b0;
    tick;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
- Single-master to 4-slave Wishbone classic interconnect stage, sitting directly upstream of the peripherals (timer, GPIO, UART, ...).
- Decodes the master address and forwards one registered transaction at a time to the selected slave.
- Returns that slave's read data and ack to the master.
- Unmapped addresses and silent slaves produce a bus error instead of hanging the core.

Parameters:
TIMEOUT_CYCLES, 16, slave-stb cycles allowed without s_ack before a timeout error (legal range 2..255)
SLAVE_SHIFT, 12, bit position of the 4-bit slave index field in m_addr

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
m_cyc  input  1  master cycle
m_stb  input  1  master strobe
m_we  input  1  master write enable
m_addr  input  32  master byte address
m_data_i  input  32  master write data
m_data_o  output  32  read data to master
m_ack  output  1  transaction complete, one-cycle pulse
m_err  output  1  bus error (unmapped or timeout), one-cycle pulse
s_cyc  output  4  per-slave cycle, one-hot or zero
s_stb  output  4  per-slave strobe, one-hot or zero
s_we  output  1  shared write enable to slaves
s_addr  output  32  shared address to slaves, full m_addr copy
s_data_o  output  32  shared write data to slaves
s_data_i  input  128  packed slave read data, slave k at [32k+31:32k]
s_ack  input  4  per-slave ack

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, latched slave index 0.
- Every output is registered.
- Address decode:
  - idx = m_addr[SLAVE_SHIFT+3:SLAVE_SHIFT].
  - The access is mapped iff idx<4 and m_addr[31:SLAVE_SHIFT+4]==0.
  - Bits below SLAVE_SHIFT pass through unchanged in s_addr.
- FSM states: IDLE, ACTIVE, ERR.
- IDLE:
  - A request is m_cyc && m_stb && !m_ack && !m_err. The guard prevents re-issuing the transaction the master is still holding during the response cycle.
  - Mapped request: latch idx, s_we<=m_we, s_addr<=m_addr, s_data_o<=m_data_i, s_cyc[idx]<=1, s_stb[idx]<=1, counter<=0, go to ACTIVE.
  - Unmapped request: m_err<=1 next cycle, go to ERR, no slave is strobed.
- ACTIVE:
  - s_ack[idx]==1: s_cyc<=0, s_stb<=0, m_data_o<=s_data_i[idx] (write data is don't-care), m_ack<=1, go to IDLE.
  - Otherwise: counter<=counter+1. When counter==TIMEOUT_CYCLES-1 and no ack: drop s_cyc/s_stb, m_err<=1, go to IDLE.
  - Ack and timeout in the same cycle: ack wins.
  - m_cyc==0 (master abort): drop s_cyc/s_stb, go to IDLE, no m_ack or m_err.
  - s_ack on non-selected slaves is ignored.
- ERR: m_err high for this one cycle only, then IDLE.
- m_ack and m_err are single-cycle pulses and are never high together.
- m_data_o holds its last value except on a read-ack update.
- Latency with a registered-ack slave: master stb at cycle 0 -> s_stb at cycle 1 -> s_ack at cycle 2 -> m_ack with data at cycle 3.
- A late s_ack arriving in IDLE, after a timeout or abort, is ignored.
- Reset mid-transaction clears everything immediately. The slave sees its stb drop asynchronously.
- One outstanding transaction at a time; no pipelining.

Decomposition:
- Package wb_pkg:
  - state enum {IDLE, ACTIVE, ERR}
  - NUM_SLAVES=4 and slave-index width 2
  - default SLAVE_SHIFT
  - timeout counter width 8
- Sub-module wb_addr_decode (combinational): maps m_addr to idx and mapped. It is reused by the future instruction-side decoder.

Test Plan:
- Read slave 1: m_addr=0x0000_1000, m_we=0; slave 1 acks the cycle after its s_stb with 0xDEAD_BEEF -> s_stb=4'b0010 at cycle 1, m_ack=1 and m_data_o=0xDEAD_BEEF at cycle 3, s_stb=0 at cycle 3.
- Write slave 0: m_addr=0x0000_0004, m_data_i=0x0000_0001, m_we=1 -> s_addr=0x4, s_data_o=1, s_we=1, s_stb=4'b0001, single m_ack pulse; master holding stb through the ack cycle produces no second s_stb.
- Unmapped: m_addr=0x0001_0000, then separately m_addr=0x0000_5000 -> no s_stb asserted, m_err=1 for exactly one cycle at cycle 1, m_ack stays 0.
- Timeout: slave 2 never acks, TIMEOUT_CYCLES=16 -> s_stb[2] high for exactly 16 cycles, then m_err pulse. A late s_ack[2] five cycles later causes no m_ack.
- Boundary: s_ack arrives on the 16th stb cycle -> m_ack=1, m_err=0. Master drops m_cyc at ACTIVE cycle 3 -> s_stb=0 next cycle, no m_ack/m_err. Back-to-back reads to slaves 0 then 3 both complete with correct data.
- Reset: assert rst during ACTIVE -> s_cyc, s_stb, m_ack, m_err, m_data_o go to 0 immediately. The first request after release completes normally.
